// File: rtl/sync_em_pkg.sv
// Embedded-sync code constants and shared enums, used by the transmitter and the receiver.
package sync_em_pkg;

    localparam int unsigned CNT_W = 12;
    localparam int unsigned BYTE_W = 8;

    localparam logic [BYTE_W-1:0] SYNC_FF    = 8'hFF;
    localparam logic [BYTE_W-1:0] SYNC_00    = 8'h00;
    localparam logic [BYTE_W-1:0] XY_SAV_BLK = 8'hAB;
    localparam logic [BYTE_W-1:0] XY_SAV_VLD = 8'h80;
    localparam logic [BYTE_W-1:0] XY_EAV_BLK = 8'hB6;
    localparam logic [BYTE_W-1:0] XY_EAV_VLD = 8'h9D;
    localparam logic [BYTE_W-1:0] FILLER     = 8'h10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SAV,
        ST_LEAD,
        ST_ACT,
        ST_TAIL,
        ST_EAV,
        ST_HBL
    } h_state_t;

    typedef enum logic [1:0] {
        LT_BLANK,
        LT_PRE,
        LT_ACTIVE
    } line_type_t;

    // Keep payload away from the reserved 0xFF/0x00 values so it never forms a sync code.
    function automatic logic [BYTE_W-1:0] pix_clip(input logic [BYTE_W-1:0] p);
        if (p == 8'hFF) return 8'hFE;
        if (p == 8'h00) return 8'h01;
        return p;
    endfunction

    // Byte n (0..3) of an FF 00 00 XY sync word.
    function automatic logic [BYTE_W-1:0] sync_byte(input logic [1:0] n,
                                                    input logic [BYTE_W-1:0] xy);
        case (n)
            2'd0:    return SYNC_FF;
            2'd3:    return xy;
            default: return SYNC_00;
        endcase
    endfunction

endpackage

// File: rtl/sync_sp2em.sv
// Embedded-sync video transmitter: emits SAV/EAV-framed lines and inserts upstream pixels.
module sync_sp2em
    import sync_em_pkg::*;
#(
    parameter int unsigned H_LEAD   = 48,
    parameter int unsigned H_ACTIVE = 1920,
    parameter int unsigned H_TAIL   = 0,
    parameter int unsigned H_BLANK  = 200,
    parameter int unsigned V_BLANK  = 20,
    parameter int unsigned V_PRE    = 25,
    parameter int unsigned V_ACTIVE = 1080
) (
    input  logic              pclk,
    input  logic              rst,
    input  logic              en,
    input  logic [BYTE_W-1:0] pix_data,
    output logic              pix_req,
    output logic [BYTE_W-1:0] dataout,
    output logic              frame_start,
    output logic [CNT_W-1:0]  line_idx,
    output logic              busy
);

    localparam logic [CNT_W-1:0] LEAD_LAST = CNT_W'(H_LEAD - 1);
    localparam logic [CNT_W-1:0] ACT_LAST  = CNT_W'(H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] TAIL_LAST = CNT_W'(H_TAIL - 1);
    localparam logic [CNT_W-1:0] HBL_LAST  = CNT_W'(H_BLANK - 1);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(3);
    localparam logic [CNT_W-1:0] VB_END    = CNT_W'(V_BLANK);
    localparam logic [CNT_W-1:0] VP_END    = CNT_W'(V_BLANK + V_PRE);
    localparam logic [CNT_W-1:0] V_LAST    = CNT_W'(V_BLANK + V_PRE + V_ACTIVE - 1);

    h_state_t          state_q, state_d;
    logic [CNT_W-1:0]  hcnt_q, hcnt_d;
    logic [CNT_W-1:0]  vcnt_q, vcnt_d;
    line_type_t        ltype_q, ltype_c;
    logic [BYTE_W-1:0] byte_c;
    logic [BYTE_W-1:0] xy_sav_c, xy_eav_c;
    logic              sav_first_c;
    logic              pix_req_c;

    // Line type of the line about to start; latched when its SAV 0xFF goes out.
    always_comb begin
        ltype_c = LT_ACTIVE;
        if (vcnt_q < VB_END)      ltype_c = LT_BLANK;
        else if (vcnt_q < VP_END) ltype_c = LT_PRE;
    end

    assign xy_sav_c    = (ltype_q == LT_BLANK) ? XY_SAV_BLK : XY_SAV_VLD;
    assign xy_eav_c    = (ltype_q == LT_BLANK) ? XY_EAV_BLK : XY_EAV_VLD;
    assign sav_first_c = (state_q == ST_SAV) && (hcnt_q == '0);

    // Next-state, counters and the byte to register onto dataout.
    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q + CNT_W'(1);
        vcnt_d  = vcnt_q;
        byte_c  = FILLER;
        case (state_q)
            ST_IDLE: begin
                hcnt_d = '0;
                vcnt_d = '0;
                if (en) state_d = ST_SAV;
            end
            ST_SAV: begin
                byte_c = sync_byte(hcnt_q[1:0], xy_sav_c);
                if (hcnt_q == SYNC_LAST) begin
                    hcnt_d  = '0;
                    state_d = (H_LEAD != 0) ? ST_LEAD : ST_ACT;
                end
            end
            ST_LEAD: begin
                if (hcnt_q == LEAD_LAST) begin
                    hcnt_d  = '0;
                    state_d = ST_ACT;
                end
            end
            ST_ACT: begin
                if (ltype_q == LT_ACTIVE) byte_c = pix_clip(pix_data);
                if (hcnt_q == ACT_LAST) begin
                    hcnt_d  = '0;
                    state_d = (H_TAIL != 0) ? ST_TAIL : ST_EAV;
                end
            end
            ST_TAIL: begin
                if (hcnt_q == TAIL_LAST) begin
                    hcnt_d  = '0;
                    state_d = ST_EAV;
                end
            end
            ST_EAV: begin
                byte_c = sync_byte(hcnt_q[1:0], xy_eav_c);
                if (hcnt_q == SYNC_LAST) begin
                    hcnt_d  = '0;
                    state_d = ST_HBL;
                end
            end
            ST_HBL: begin
                if (hcnt_q == HBL_LAST) begin
                    hcnt_d = '0;
                    if (vcnt_q == V_LAST) begin
                        vcnt_d  = '0;
                        state_d = en ? ST_SAV : ST_IDLE;
                    end else begin
                        vcnt_d  = vcnt_q + CNT_W'(1);
                        state_d = ST_SAV;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // pix_req leads the ACT byte by one cycle so the pixel is captured on the emitting edge.
    assign pix_req_c = (state_d == ST_ACT) && (ltype_q == LT_ACTIVE);

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            ltype_q     <= LT_BLANK;
            dataout     <= FILLER;
            pix_req     <= 1'b0;
            frame_start <= 1'b0;
            line_idx    <= '0;
            busy        <= 1'b0;
        end else begin
            state_q     <= state_d;
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            dataout     <= byte_c;
            pix_req     <= pix_req_c;
            frame_start <= sav_first_c && (vcnt_q == '0);
            busy        <= (state_q != ST_IDLE);
            if (sav_first_c) begin
                ltype_q  <= ltype_c;
                line_idx <= vcnt_q;
            end
        end
    end

endmodule

// File: tb/tb_sync_sp2em.sv
// Directed bench for sync_sp2em with a 4-line, 17-byte-per-line toy frame.
module tb_sync_sp2em;

    localparam int FRAME = 68;
    localparam int LINE  = 17;

    logic        pclk = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  pix_data;
    logic        pix_req;
    logic [7:0]  dataout;
    logic        frame_start;
    logic [11:0] line_idx;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] pix_tab [8];
    int         pidx;

    logic [7:0]  cap_data [FRAME];
    logic        cap_req  [FRAME];
    logic        cap_fs   [FRAME];
    logic        cap_busy [FRAME];
    logic [11:0] cap_line [FRAME];

    sync_sp2em #(
        .H_LEAD(2), .H_ACTIVE(4), .H_TAIL(0), .H_BLANK(3),
        .V_BLANK(1), .V_PRE(1), .V_ACTIVE(2)
    ) dut (
        .pclk(pclk), .rst(rst), .en(en), .pix_data(pix_data),
        .pix_req(pix_req), .dataout(dataout), .frame_start(frame_start),
        .line_idx(line_idx), .busy(busy)
    );

    always #5 pclk = ~pclk;

    // Upstream source: present the next table entry whenever a request is seen.
    initial begin
        pix_data = 8'h00;
        pidx     = 0;
        forever begin
            @(negedge pclk);
            if (pix_req === 1'b1) begin
                pix_data = pix_tab[pidx % 8];
                pidx++;
            end
        end
    end

    function automatic logic [7:0] exp_byte(input int i);
        int ln  = i / LINE;
        int pos = i % LINE;
        logic [7:0] l2 [4] = '{8'h01, 8'h02, 8'h03, 8'h04};
        logic [7:0] l3 [4] = '{8'hFE, 8'h01, 8'h7F, 8'h80};
        case (pos)
            0, 10:        return 8'hFF;
            1, 2, 11, 12: return 8'h00;
            3:            return (ln == 0) ? 8'hAB : 8'h80;
            13:           return (ln == 0) ? 8'hB6 : 8'h9D;
            6, 7, 8, 9: begin
                if (ln == 2) return l2[pos-6];
                if (ln == 3) return l3[pos-6];
                return 8'h10;
            end
            default:      return 8'h10;
        endcase
    endfunction

    function automatic logic exp_req(input int i);
        return ((i / LINE) >= 2) && ((i % LINE) >= 5) && ((i % LINE) <= 8);
    endfunction

    task automatic capture_frame(input int drop_at);
        for (int i = 0; i < FRAME; i++) begin
            if (i == drop_at) en = 1'b0;
            @(negedge pclk);
            cap_data[i] = dataout;
            cap_req[i]  = pix_req;
            cap_fs[i]   = frame_start;
            cap_busy[i] = busy;
            cap_line[i] = line_idx;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        en  = 1'b0;
        repeat (3) @(negedge pclk);
        n_checks++; if (dataout !== 8'h10) begin n_fail++; $display("FAIL reset_dataout got=%h exp=10", dataout); end
        n_checks++; if (pix_req !== 1'b0) begin n_fail++; $display("FAIL reset_pix_req got=%b exp=0", pix_req); end
        n_checks++; if (frame_start !== 1'b0) begin n_fail++; $display("FAIL reset_frame_start got=%b exp=0", frame_start); end
        n_checks++; if (line_idx !== 12'd0) begin n_fail++; $display("FAIL reset_line_idx got=%0d exp=0", line_idx); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
        rst = 1'b0;
        @(negedge pclk);
        n_checks++; if (dataout !== 8'h10 || busy !== 1'b0) begin n_fail++; $display("FAIL idle_hold got=%h/%b exp=10/0", dataout, busy); end
    endtask

    task automatic test_blank_lines;
        en = 1'b1;
        @(negedge pclk);
        n_checks++; if (dataout !== 8'h10 || busy !== 1'b0) begin n_fail++; $display("FAIL start_latency got=%h/%b exp=10/0", dataout, busy); end
        capture_frame(-1);
        for (int i = 0; i < 2 * LINE; i++) begin
            n_checks++; if (cap_data[i] !== exp_byte(i)) begin n_fail++; $display("FAIL blank_data[%0d] got=%h exp=%h", i, cap_data[i], exp_byte(i)); end
            n_checks++; if (cap_req[i] !== 1'b0) begin n_fail++; $display("FAIL blank_req[%0d] got=%b exp=0", i, cap_req[i]); end
            n_checks++; if (cap_fs[i] !== (i == 0)) begin n_fail++; $display("FAIL blank_fs[%0d] got=%b exp=%b", i, cap_fs[i], i == 0); end
            n_checks++; if (cap_busy[i] !== 1'b1) begin n_fail++; $display("FAIL blank_busy[%0d] got=%b exp=1", i, cap_busy[i]); end
            n_checks++; if (cap_line[i] !== 12'(i / LINE)) begin n_fail++; $display("FAIL blank_line[%0d] got=%0d exp=%0d", i, cap_line[i], i / LINE); end
        end
    endtask

    task automatic test_active_pixels;
        for (int i = 2 * LINE; i < FRAME; i++) begin
            n_checks++; if (cap_data[i] !== exp_byte(i)) begin n_fail++; $display("FAIL act_data[%0d] got=%h exp=%h", i, cap_data[i], exp_byte(i)); end
            n_checks++; if (cap_req[i] !== exp_req(i)) begin n_fail++; $display("FAIL act_req[%0d] got=%b exp=%b", i, cap_req[i], exp_req(i)); end
            n_checks++; if (cap_line[i] !== 12'(i / LINE)) begin n_fail++; $display("FAIL act_line[%0d] got=%0d exp=%0d", i, cap_line[i], i / LINE); end
            n_checks++; if (cap_fs[i] !== 1'b0) begin n_fail++; $display("FAIL act_fs[%0d] got=%b exp=0", i, cap_fs[i]); end
        end
        n_checks++; if (pidx !== 8) begin n_fail++; $display("FAIL req_count got=%0d exp=8", pidx); end
    endtask

    task automatic test_back_to_back;
        capture_frame(-1);
        n_checks++; if (cap_fs[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_fs got=%b exp=1", cap_fs[0]); end
        for (int i = 0; i < FRAME; i++) begin
            n_checks++; if (cap_data[i] !== exp_byte(i)) begin n_fail++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, cap_data[i], exp_byte(i)); end
            n_checks++; if (cap_busy[i] !== 1'b1) begin n_fail++; $display("FAIL b2b_busy[%0d] got=%b exp=1", i, cap_busy[i]); end
        end
        n_checks++; if (pidx !== 16) begin n_fail++; $display("FAIL b2b_req_count got=%0d exp=16", pidx); end
    endtask

    task automatic test_en_drop;
        capture_frame(20);
        for (int i = 0; i < FRAME; i++) begin
            n_checks++; if (cap_data[i] !== exp_byte(i)) begin n_fail++; $display("FAIL drop_data[%0d] got=%h exp=%h", i, cap_data[i], exp_byte(i)); end
            n_checks++; if (cap_busy[i] !== 1'b1) begin n_fail++; $display("FAIL drop_busy[%0d] got=%b exp=1", i, cap_busy[i]); end
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge pclk);
            n_checks++; if (dataout !== 8'h10 || busy !== 1'b0 || frame_start !== 1'b0 || pix_req !== 1'b0)
                begin n_fail++; $display("FAIL drop_idle[%0d] got=%h/%b/%b/%b exp=10/0/0/0", k, dataout, busy, frame_start, pix_req); end
        end
        en = 1'b1;
        @(negedge pclk);
        n_checks++; if (dataout !== 8'h10) begin n_fail++; $display("FAIL restart_latency got=%h exp=10", dataout); end
        @(negedge pclk);
        n_checks++; if (dataout !== 8'hFF || frame_start !== 1'b1 || busy !== 1'b1)
            begin n_fail++; $display("FAIL restart_sav got=%h/%b/%b exp=ff/1/1", dataout, frame_start, busy); end
    endtask

    task automatic test_rst_mid_line;
        repeat (39) @(negedge pclk);
        n_checks++; if (pix_req !== 1'b1) begin n_fail++; $display("FAIL mid_req got=%b exp=1", pix_req); end
        @(negedge pclk);
        n_checks++; if (dataout !== 8'h01 || line_idx !== 12'd2) begin n_fail++; $display("FAIL mid_pixel got=%h/%0d exp=01/2", dataout, line_idx); end
        #1 rst = 1'b1;
        #1;
        n_checks++; if (dataout !== 8'h10 || pix_req !== 1'b0 || busy !== 1'b0 || line_idx !== 12'd0 || frame_start !== 1'b0)
            begin n_fail++; $display("FAIL async_rst got=%h/%b/%b/%0d/%b exp=10/0/0/0/0", dataout, pix_req, busy, line_idx, frame_start); end
        @(negedge pclk);
        rst  = 1'b0;
        pidx = 0;
        @(negedge pclk);
        n_checks++; if (dataout !== 8'h10 || busy !== 1'b0) begin n_fail++; $display("FAIL rst_restart_latency got=%h/%b exp=10/0", dataout, busy); end
        capture_frame(-1);
        n_checks++; if (cap_fs[0] !== 1'b1 || cap_line[0] !== 12'd0) begin n_fail++; $display("FAIL rst_restart_fs got=%b/%0d exp=1/0", cap_fs[0], cap_line[0]); end
        for (int i = 0; i < FRAME; i++) begin
            n_checks++; if (cap_data[i] !== exp_byte(i)) begin n_fail++; $display("FAIL rst_data[%0d] got=%h exp=%h", i, cap_data[i], exp_byte(i)); end
            n_checks++; if (cap_req[i] !== exp_req(i)) begin n_fail++; $display("FAIL rst_req[%0d] got=%b exp=%b", i, cap_req[i], exp_req(i)); end
        end
        en = 1'b0;
    endtask

    initial begin
        pix_tab = '{8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'h00, 8'h7F, 8'h80};
        test_reset();
        test_blank_lines();
        test_active_pixels();
        test_back_to_back();
        test_en_drop();
        test_rst_mid_line();
        repeat (2) @(negedge pclk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
